// File: rtl/thiele_cpu.sv
// rtl/thiele_cpu.sv - multicycle Thiele-machine CPU: XOR compute ops, partition/MDL bookkeeping, mu cost, co-processor ports
// Optional: define CHSH_TRIAL_EN to make opcode 0x09 (CHSH_TRIAL) legal.
module thiele_cpu #(
  parameter int NUM_MODULES = 64,
  parameter int MAX_REGION  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] cert_addr,
  output logic [31:0] status,
  output logic [31:0] error_code,
  output logic [31:0] partition_ops,
  output logic [31:0] mdl_ops,
  output logic [31:0] info_gain,
  output logic [31:0] mu,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_en,
  output logic        logic_req,
  output logic [31:0] logic_addr,
  input  logic        logic_ack,
  input  logic [31:0] logic_data,
  output logic        py_req,
  output logic [31:0] py_code_addr,
  input  logic        py_ack,
  input  logic [31:0] py_result,
  input  logic [31:0] instr_data,
  output logic [31:0] pc
);

  localparam int ID_W = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_PNEW   = 8'h01;
  localparam logic [7:0] OP_CERT   = 8'h03;
  localparam logic [7:0] OP_MDLACC = 8'h05;
  localparam logic [7:0] OP_XFER   = 8'h07;
  localparam logic [7:0] OP_CHSH   = 8'h09;
  localparam logic [7:0] OP_LOAD   = 8'h0A;
  localparam logic [7:0] OP_XADD   = 8'h0B;
  localparam logic [7:0] OP_SWAP   = 8'h0C;
  localparam logic [7:0] OP_RANK   = 8'h0D;
  localparam logic [7:0] OP_REV    = 8'h0E;
  localparam logic [7:0] OP_PARITY = 8'h0F;
  localparam logic [7:0] OP_AND    = 8'h10;
  localparam logic [7:0] OP_STORE  = 8'h11;
  localparam logic [7:0] OP_ORACLE = 8'h13;
  localparam logic [7:0] OP_PYEXEC = 8'h14;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef enum logic [3:0] {
    FETCH      = 4'd0,
    DECODE     = 4'd1,
    EXECUTE    = 4'd2,
    LOGIC_WAIT = 4'd3,
    PY_WAIT    = 4'd4,
    HALTED     = 4'd5
  } state_t;

  state_t state, next_state;

  logic [7:0]  opcode, operand_a, operand_b, cost;
  logic [31:0] reg_file     [0:31];
  logic [31:0] data_mem     [0:255];
  logic [7:0]  module_table [0:NUM_MODULES-1];
  logic [7:0]  region_table [0:NUM_MODULES-1][0:MAX_REGION-1];

  logic [4:0]  ra, rb;
  logic [31:0] va, vb;
  logic [31:0] popcnt, rev_b;
  logic        free_found;
  logic [ID_W-1:0] free_id;
  logic        op_legal;
  logic        pnew_full;
  logic        unused_mem_rdata;

  assign ra = operand_a[4:0];
  assign rb = operand_b[4:0];
  assign va = reg_file[ra];
  assign vb = reg_file[rb];

  assign mem_addr         = '0;
  assign mem_wdata        = '0;
  assign mem_we           = 1'b0;
  assign mem_en           = 1'b0;
  assign unused_mem_rdata = ^mem_rdata;

  assign status = {27'b0, (state == HALTED), state};

  always_comb begin
    popcnt = '0;
    rev_b  = '0;
    for (int i = 0; i < 32; i++) begin
      popcnt   = popcnt + 32'(vb[i]);
      rev_b[i] = vb[31-i];
    end
  end

  // Descending scan so the last hit is the lowest free module id.
  always_comb begin
    free_found = 1'b0;
    free_id    = '0;
    for (int i = NUM_MODULES-1; i >= 0; i--) begin
      if (module_table[i] == 8'd0) begin
        free_found = 1'b1;
        free_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    case (opcode)
      OP_NOP, OP_PNEW, OP_CERT, OP_MDLACC, OP_XFER, OP_LOAD, OP_XADD, OP_SWAP,
      OP_RANK, OP_REV, OP_PARITY, OP_AND, OP_STORE, OP_ORACLE, OP_PYEXEC,
      OP_HALT: op_legal = 1'b1;
`ifdef CHSH_TRIAL_EN
      OP_CHSH: op_legal = (operand_a < 8'd4) && (operand_b < 8'd4);
`endif
      default: op_legal = 1'b0;
    endcase
  end

  assign pnew_full = (opcode == OP_PNEW) && !free_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      FETCH:   next_state = DECODE;
      DECODE:  next_state = EXECUTE;
      EXECUTE: begin
        if (!op_legal || pnew_full || opcode == OP_HALT) next_state = HALTED;
        else if (opcode == OP_ORACLE)                    next_state = LOGIC_WAIT;
        else if (opcode == OP_PYEXEC)                    next_state = PY_WAIT;
        else                                             next_state = FETCH;
      end
      LOGIC_WAIT: if (logic_ack) next_state = FETCH;
      PY_WAIT:    if (py_ack)    next_state = FETCH;
      HALTED:     next_state = HALTED;
      default:    next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= '0;
      opcode        <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      cost          <= '0;
      cert_addr     <= '0;
      error_code    <= '0;
      partition_ops <= '0;
      mdl_ops       <= '0;
      info_gain     <= '0;
      mu            <= '0;
      logic_req     <= 1'b0;
      logic_addr    <= '0;
      py_req        <= 1'b0;
      py_code_addr  <= '0;
      for (int i = 0; i < 32; i++)  reg_file[i] <= '0;
      for (int i = 0; i < 256; i++) data_mem[i] <= '0;
      for (int i = 0; i < NUM_MODULES; i++) begin
        module_table[i] <= '0;
        for (int j = 0; j < MAX_REGION; j++) region_table[i][j] <= '0;
      end
    end else begin
      case (state)
        FETCH: {opcode, operand_a, operand_b, cost} <= instr_data;
        EXECUTE: begin
          if (!op_legal) begin
            error_code <= 32'd1;
          end else if (pnew_full) begin
            error_code <= 32'd2;
          end else begin
            mu <= mu + {24'b0, cost};
            // Co-processor ops advance pc on ack; HALT leaves pc on itself.
            if (opcode != OP_HALT && opcode != OP_ORACLE && opcode != OP_PYEXEC)
              pc <= pc + 32'd4;
            case (opcode)
              OP_PNEW: begin
                module_table[free_id]    <= 8'd1;
                region_table[free_id][0] <= operand_a;
                partition_ops            <= partition_ops + 32'd1;
              end
              OP_CERT:   cert_addr <= va;
              OP_MDLACC: begin
                mdl_ops   <= mdl_ops + 32'd1;
                info_gain <= info_gain + va;
              end
              OP_XFER:   reg_file[rb] <= va;
              OP_LOAD:   reg_file[ra] <= data_mem[operand_b];
              OP_XADD:   reg_file[ra] <= va ^ vb;
              OP_SWAP: begin
                reg_file[ra] <= vb;
                reg_file[rb] <= va;
              end
              OP_RANK:   reg_file[ra] <= popcnt;
              OP_REV:    reg_file[ra] <= rev_b;
              OP_PARITY: reg_file[ra] <= {31'b0, ^vb};
              OP_AND:    reg_file[ra] <= va & vb;
              OP_STORE:  data_mem[operand_b] <= va;
              OP_ORACLE: begin
                logic_addr <= va;
                logic_req  <= 1'b1;
              end
              OP_PYEXEC: begin
                py_code_addr <= {24'b0, operand_b};
                py_req       <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        LOGIC_WAIT: if (logic_ack) begin
          reg_file[rb] <= logic_data;
          logic_req    <= 1'b0;
          pc           <= pc + 32'd4;
        end
        PY_WAIT: if (py_ack) begin
          reg_file[ra] <= py_result;
          py_req       <= 1'b0;
          pc           <= pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_thiele_cpu.sv
// tb/tb_thiele_cpu.sv - scoreboard bench for thiele_cpu with directed programs
module tb_thiele_cpu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cert_addr, status, error_code, partition_ops, mdl_ops, info_gain, mu;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_we, mem_en;
  logic        logic_req, logic_ack, py_req, py_ack;
  logic [31:0] logic_addr, logic_data, py_code_addr, py_result;
  logic [31:0] instr_data, pc;

  logic [31:0] rom [0:127];

  thiele_cpu dut (
    .clk(clk), .rst_n(rst_n), .cert_addr(cert_addr), .status(status),
    .error_code(error_code), .partition_ops(partition_ops), .mdl_ops(mdl_ops),
    .info_gain(info_gain), .mu(mu), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_en(mem_en),
    .logic_req(logic_req), .logic_addr(logic_addr), .logic_ack(logic_ack),
    .logic_data(logic_data), .py_req(py_req), .py_code_addr(py_code_addr),
    .py_ack(py_ack), .py_result(py_result), .instr_data(instr_data), .pc(pc)
  );

  always #5 clk = ~clk;
  assign instr_data = rom[pc[8:2]];

  localparam int K_REG = 0, K_MEM = 1, K_PC = 2, K_ERR = 3, K_MU = 4, K_LADDR = 5,
                 K_PADDR = 6, K_STATUS = 7, K_MOD = 8, K_REGION = 9, K_POPS = 10,
                 K_TB = 11, K_CERT = 12, K_MDL = 13, K_GAIN = 14, K_REQS = 15;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] exp;
    bit          at_halt;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int miscompares = 0;
  int halt_age = 0;
  int cyc = 0;

  int lg_delay = 0, lg_hold = 1, py_delay = 0;
  logic [31:0] lg_resp = '0, lg_resp2 = '0, py_resp = '0;
  int lg_req_cycles = 0, lg_req_after = 0, lg_early = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           halt_age <= 0;
    else if (!status[4])                  halt_age <= 0;
    else if (halt_age < 100)              halt_age <= halt_age + 1;
  end

  always @(posedge clk) begin
    if (!rst_n)          cyc <= 0;
    else if (!status[4]) cyc <= cyc + 1;
  end

  initial begin : logic_responder
    logic_ack  = 1'b0;
    logic_data = '0;
    forever begin
      @(negedge clk);
      if (logic_req) begin
        for (int i = 0; i < lg_delay; i++) begin
          @(negedge clk);
          if (logic_req) lg_req_cycles++;
          else           lg_early++;
        end
        logic_data = lg_resp;
        logic_ack  = 1'b1;
        @(negedge clk);
        lg_req_after = int'(logic_req);
        logic_data   = lg_resp2;
        repeat (lg_hold - 1) @(negedge clk);
        logic_ack = 1'b0;
      end
    end
  end

  initial begin : py_responder
    py_ack    = 1'b0;
    py_result = '0;
    forever begin
      @(negedge clk);
      if (py_req) begin
        repeat (py_delay) @(negedge clk);
        py_result = py_resp;
        py_ack    = 1'b1;
        @(negedge clk);
        py_ack = 1'b0;
      end
    end
  end

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_REG: return "reg";        K_MEM: return "mem";       K_PC: return "pc";
      K_ERR: return "error_code"; K_MU: return "mu";         K_LADDR: return "logic_addr";
      K_PADDR: return "py_code_addr"; K_STATUS: return "status"; K_MOD: return "module_table";
      K_REGION: return "region_table0"; K_POPS: return "partition_ops"; K_TB: return "measure";
      K_CERT: return "cert_addr"; K_MDL: return "mdl_ops";   K_GAIN: return "info_gain";
      default: return "reqs";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int k, input int idx);
    case (k)
      K_REG:    return dut.reg_file[idx];
      K_MEM:    return dut.data_mem[idx];
      K_PC:     return pc;
      K_ERR:    return error_code;
      K_MU:     return mu;
      K_LADDR:  return logic_addr;
      K_PADDR:  return py_code_addr;
      K_STATUS: return status;
      K_MOD:    return {24'b0, dut.module_table[idx]};
      K_REGION: return {24'b0, dut.region_table[idx][0]};
      K_POPS:   return partition_ops;
      K_TB: case (idx)
              0: return 32'(cyc);
              1: return 32'(lg_req_cycles);
              2: return 32'(lg_req_after);
              default: return 32'(lg_early);
            endcase
      K_CERT:   return cert_addr;
      K_MDL:    return mdl_ops;
      K_GAIN:   return info_gain;
      default:  return {30'b0, py_req, logic_req};
    endcase
  endfunction

  task automatic check(input exp_t e);
    logic [31:0] act;
    act = actual(e.kind, e.idx);
    vectors++;
    if (act !== e.exp) begin
      miscompares++;
      $display("FAIL %s[%0d]: got 0x%08h, required 0x%08h", kname(e.kind), e.idx, act, e.exp);
    end
  endtask

  initial begin : monitor
    int budget;
    exp_t e;
    budget = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() == 0) begin
        budget = 0;
      end else if (sb_q[0].at_halt && halt_age < 4) begin
        budget++;
        if (budget > 3000) begin
          $display("FAIL halt_timeout: got no halt after %0d cycles, required halt", budget);
          vectors++;
          miscompares++;
          sb_q.delete();
          budget = 0;
        end
      end else begin
        budget = 0;
        while (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check(e);
        end
      end
    end
  end

  task automatic expect_v(input int k, input int idx, input logic [31:0] v, input bit ah = 1'b1);
    exp_t e;
    e.kind = k; e.idx = idx; e.exp = v; e.at_halt = ah;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      $display("FAIL drain: got %0d pending checks, required 0", sb_q.size());
      $fatal(1);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = ins(8'hFF, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic start_prog();
    @(negedge clk);
    rst_n = 1'b0;
    lg_req_cycles = 0; lg_req_after = 0; lg_early = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stimulus
    int n;
    clear_rom();

    // Default program.
    rom[0]  = ins(8'h0A, 8'd0, 8'd0, 8'd0);
    rom[1]  = ins(8'h0A, 8'd1, 8'd1, 8'd0);
    rom[2]  = ins(8'h0A, 8'd2, 8'd2, 8'd0);
    rom[3]  = ins(8'h0A, 8'd3, 8'd3, 8'd0);
    rom[4]  = ins(8'h0B, 8'd3, 8'd0, 8'd0);
    rom[5]  = ins(8'h0B, 8'd3, 8'd1, 8'd0);
    rom[6]  = ins(8'h0C, 8'd0, 8'd3, 8'd0);
    rom[7]  = ins(8'h07, 8'd2, 8'd4, 8'd0);
    rom[8]  = ins(8'h0D, 8'd5, 8'd2, 8'd0);
    rom[9]  = ins(8'h0E, 8'd6, 8'd2, 8'd0);
    rom[10] = ins(8'h0F, 8'd7, 8'd3, 8'd0);
    rom[11] = ins(8'h10, 8'd1, 8'd2, 8'd0);
    rom[12] = ins(8'h11, 8'd5, 8'd4, 8'd0);
    rom[13] = ins(8'h11, 8'd6, 8'd5, 8'd0);
    rom[14] = ins(8'h11, 8'd7, 8'd6, 8'd0);
    rom[15] = ins(8'h13, 8'd0, 8'd8, 8'd0);
    rom[16] = ins(8'h14, 8'd9, 8'd0, 8'd0);
    rom[17] = ins(8'hFF, 8'd0, 8'd0, 8'd0);
    lg_delay = 3; lg_hold = 1; lg_resp = 32'hABCD1234; lg_resp2 = 32'hABCD1234;
    py_delay = 2; py_resp = 32'h12345678;
    start_prog();
    dut.data_mem[0] = 32'h29;
    dut.data_mem[1] = 32'h12;
    dut.data_mem[2] = 32'h22;
    dut.data_mem[3] = 32'h03;
    expect_v(K_REG, 0, 32'h38);       expect_v(K_REG, 1, 32'h02);
    expect_v(K_REG, 2, 32'h22);       expect_v(K_REG, 3, 32'h29);
    expect_v(K_REG, 4, 32'h22);       expect_v(K_REG, 5, 32'd2);
    expect_v(K_REG, 6, 32'h44000000); expect_v(K_REG, 7, 32'd1);
    expect_v(K_REG, 8, 32'hABCD1234); expect_v(K_REG, 9, 32'h12345678);
    expect_v(K_MEM, 4, 32'd2);        expect_v(K_MEM, 5, 32'h44000000);
    expect_v(K_MEM, 6, 32'd1);        expect_v(K_PC, 0, 32'h44);
    expect_v(K_ERR, 0, 32'd0);        expect_v(K_MU, 0, 32'd0);
    expect_v(K_LADDR, 0, 32'h38);     expect_v(K_PADDR, 0, 32'd0);
    expect_v(K_STATUS, 0, 32'h15);    expect_v(K_REQS, 0, 32'd0);
    drain();

    // Reset state, checked while reset is held.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_v(K_PC, 0, 32'd0, 1'b0);     expect_v(K_STATUS, 0, 32'd0, 1'b0);
    expect_v(K_REG, 0, 32'd0, 1'b0);    expect_v(K_MEM, 4, 32'd0, 1'b0);
    expect_v(K_LADDR, 0, 32'd0, 1'b0);  expect_v(K_PADDR, 0, 32'd0, 1'b0);
    expect_v(K_REQS, 0, 32'd0, 1'b0);
    drain();

    // Reset in the middle of an oracle wait drops the request at once.
    clear_rom();
    rom[0] = ins(8'h13, 8'd0, 8'd8, 8'd0);
    lg_delay = 50;
    start_prog();
    n = 0;
    while (!logic_req && n < 100) begin @(negedge clk); n++; end
    expect_v(K_REQS, 0, 32'd1, 1'b0);
    drain();
    @(posedge clk);
    #2 rst_n = 1'b0;
    expect_v(K_REQS, 0, 32'd0, 1'b0);
    drain();
    repeat (60) @(negedge clk);

    // Cost accounting and HALT's single EXECUTE cycle.
    clear_rom();
    for (int i = 0; i < 3; i++) rom[i] = ins(8'h00, 8'd0, 8'd0, 8'd5);
    rom[3] = ins(8'hFF, 8'd0, 8'd0, 8'd1);
    start_prog();
    expect_v(K_MU, 0, 32'd16); expect_v(K_TB, 0, 32'd12); expect_v(K_PC, 0, 32'h0C);
    drain();

    // Two partitions.
    clear_rom();
    rom[0] = ins(8'h01, 8'd7, 8'd0, 8'd0);
    rom[1] = ins(8'h01, 8'd9, 8'd0, 8'd0);
    start_prog();
    expect_v(K_MOD, 0, 32'd1);    expect_v(K_MOD, 1, 32'd1);    expect_v(K_MOD, 2, 32'd0);
    expect_v(K_REGION, 0, 32'd7); expect_v(K_REGION, 1, 32'd9); expect_v(K_POPS, 0, 32'd2);
    expect_v(K_ERR, 0, 32'd0);
    drain();

    // CERT, MDLACC, XFER, register index wrap, self-swap.
    clear_rom();
    rom[0] = ins(8'h14, 8'h23, 8'h5A, 8'd0);
    rom[1] = ins(8'h03, 8'd3, 8'd0, 8'd0);
    rom[2] = ins(8'h05, 8'd3, 8'd0, 8'd0);
    rom[3] = ins(8'h05, 8'd3, 8'd0, 8'd0);
    rom[4] = ins(8'h07, 8'd3, 8'h25, 8'd0);
    rom[5] = ins(8'h0C, 8'd3, 8'd3, 8'd0);
    py_delay = 0; py_resp = 32'h00C0FFEE;
    start_prog();
    expect_v(K_REG, 3, 32'h00C0FFEE); expect_v(K_REG, 5, 32'h00C0FFEE);
    expect_v(K_CERT, 0, 32'h00C0FFEE); expect_v(K_MDL, 0, 32'd2);
    expect_v(K_GAIN, 0, 32'h0181FFDC); expect_v(K_PADDR, 0, 32'h5A);
    expect_v(K_PC, 0, 32'h18);
    drain();

    // 65 PNEWs overflow the module table.
    clear_rom();
    for (int i = 0; i < 65; i++) rom[i] = ins(8'h01, 8'(i), 8'd0, 8'd0);
    start_prog();
    expect_v(K_ERR, 0, 32'd2);       expect_v(K_STATUS, 0, 32'h15);
    expect_v(K_POPS, 0, 32'd64);     expect_v(K_PC, 0, 32'h100);
    expect_v(K_MOD, 63, 32'd1);      expect_v(K_REGION, 63, 32'd63);
    drain();

    // Illegal opcode freezes pc.
    clear_rom();
    rom[0] = ins(8'h00, 8'd0, 8'd0, 8'd0);
    rom[1] = ins(8'h42, 8'd0, 8'd0, 8'd0);
    start_prog();
    expect_v(K_ERR, 0, 32'd1); expect_v(K_STATUS, 0, 32'h15); expect_v(K_PC, 0, 32'h4);
    drain();

    // Oracle ack delayed 20 cycles, held high after completion with changed data.
    clear_rom();
    rom[0] = ins(8'h14, 8'd1, 8'd0, 8'd0);
    rom[1] = ins(8'h13, 8'd1, 8'd8, 8'd0);
    py_resp = 32'h0000BEEF;
    lg_delay = 20; lg_hold = 3; lg_resp = 32'h5555AAAA; lg_resp2 = 32'hDEADBEEF;
    start_prog();
    expect_v(K_REG, 8, 32'h5555AAAA); expect_v(K_LADDR, 0, 32'h0000BEEF);
    expect_v(K_TB, 1, 32'd20);        expect_v(K_TB, 2, 32'd0);
    expect_v(K_TB, 3, 32'd0);         expect_v(K_PC, 0, 32'h8);
    drain();
    lg_hold = 1;

`ifdef CHSH_TRIAL_EN
    clear_rom();
    rom[0] = ins(8'h09, 8'd2, 8'd1, 8'd3);
    start_prog();
    expect_v(K_MU, 0, 32'd3); expect_v(K_ERR, 0, 32'd0); expect_v(K_PC, 0, 32'h4);
    drain();
    clear_rom();
    rom[0] = ins(8'h09, 8'd5, 8'd1, 8'd3);
    start_prog();
    expect_v(K_ERR, 0, 32'd1); expect_v(K_PC, 0, 32'h0);
    drain();
`else
    clear_rom();
    rom[0] = ins(8'h09, 8'd2, 8'd1, 8'd3);
    start_prog();
    expect_v(K_ERR, 0, 32'd1); expect_v(K_MU, 0, 32'd0); expect_v(K_PC, 0, 32'h0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
